game_round_ctrl: RTL and testbench
==================================

Name: game_round_ctrl

Overview:
- Round/game sequencer for the Precision Button Press game.
- Replaces free-running divided clocks with single-cycle step enables on CLK that advance the LED sweeper.
- Arms each round, judges each press using the sequence detector's MATCH flag, and pulses score increment/clear to the accumulator.
- Counts rounds and misses, holds each result, and ends the game.

Parameters:
- EASY_DIV, 50_000_000: CLK cycles per sweep step when DSW=0.
- HARD_DIV, 12_500_000: CLK cycles per sweep step when DSW=1.
- HOLD_CYC, 100_000_000: CLK cycles the result is held between rounds.
- TIMEOUT_STEPS, 32: sweep steps allowed per round before an automatic miss.
- ROUNDS, 8: rounds per game; legal range 1..15.
- MAX_MISS, 3: misses that end the game early; legal range 1..3.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  raw start button; synchronized internally.
- BTN  in  1  raw player button; synchronized internally.
- DSW  in  1  difficulty switch: 0 = easy, 1 = hard.
- MATCH  in  1  detector compare result: current LED pattern equals switches.
- STEP_EN  out  1  one-cycle pulse that advances the LED sweeper.
- SWEEP_RUN  out  1  high while a round is live.
- SCORE_INC  out  1  one-cycle pulse, +1 to score.
- SCORE_CLR  out  1  one-cycle pulse, clear score.
- RESULT_HIT  out  1  high during HOLD after a hit.
- RESULT_MISS  out  1  high during HOLD after a miss or timeout.
- ROUND  out  4  completed-round count.
- MISSES  out  2  miss count.
- GAME_OVER  out  1  high in OVER.
- STATE  out  3  encoded FSM state, for debug LEDs.

Behaviour:
- Reset: asynchronous, active-high. State = IDLE. All outputs 0. All counters 0. Synchronizers cleared. Reset asserted mid-round aborts immediately with no SCORE_INC.
- Inputs: BTN and START each pass through a 2-flop synchronizer.
  - press = falling edge of synchronized BTN.
  - start = rising edge of synchronized START.
  - Latency: the BTN edge reaches the FSM 3 CLK edges after BTN first changes.
- IDLE: waits for start. On start: SCORE_CLR pulses for 1 cycle; ROUND, MISSES and RESULT_* are cleared; go to ARM.
- ARM (1 cycle):
  - Latch the divisor from DSW; DSW changes are ignored until the next ARM.
  - Clear the tick counter and the step counter.
  - Go to PLAY.
- PLAY:
  - SWEEP_RUN=1.
  - The tick counter counts 0..DIV-1; STEP_EN pulses on the cycle the counter wraps.
  - Each STEP_EN increments the step counter.
  - On press, priority over everything else in that cycle:
    - STEP_EN is suppressed.
    - MATCH is sampled in the same cycle.
    - If MATCH=1: SCORE_INC pulses and RESULT_HIT sets. Otherwise: MISSES increments (saturating at 3) and RESULT_MISS sets.
    - Go to HOLD.
  - If the step counter reaches TIMEOUT_STEPS with no press: miss, handled as above. Go to HOLD.
  - A press and a timeout in the same cycle count as a press.
- HOLD:
  - SWEEP_RUN=0, STEP_EN=0; presses are ignored.
  - Count HOLD_CYC cycles. On the last cycle: ROUND increments and RESULT_* clear.
  - If ROUND+1 == ROUNDS or MISSES == MAX_MISS, go to OVER; otherwise go to ARM.
- OVER: GAME_OVER=1; ROUND and MISSES are held. A start pulse behaves exactly as the start pulse in IDLE.
- start pulses in ARM, PLAY and HOLD are ignored.
- SCORE_INC and SCORE_CLR are never asserted in the same cycle.
- Width rules:
  - Tick counter is $clog2(max(EASY_DIV, HARD_DIV)) bits.
  - Hold counter is $clog2(HOLD_CYC) bits.
  - Step counter is $clog2(TIMEOUT_STEPS+1) bits.
  - No wrap-around is possible within legal parameter ranges.
- All outputs are registered. STATE encoding: IDLE=0, ARM=1, PLAY=2, HOLD=3, OVER=4.

Decomposition:
- Shared package game_pkg holds:
  - state_t enum (IDLE, ARM, PLAY, HOLD, OVER) with the encodings above.
  - Default divisor and timing constants, reusable by the sweeper and display blocks.
- One sub-module, step_tick_gen. Inputs: CLK, RST, clear, run, 32-bit divisor. Output: tick. The FSM and the counters stay in game_round_ctrl.

Test Plan:
All scenarios use EASY_DIV=4, HARD_DIV=2, HOLD_CYC=3, TIMEOUT_STEPS=5, ROUNDS=3, MAX_MISS=2.
- Start then timeout:
  - Stimulus: pulse START, DSW=0, no press.
  - Response: SCORE_CLR=1 for 1 cycle; STEP_EN every 4 cycles; RESULT_MISS after the 5th STEP_EN; MISSES=1; ROUND=1 after 3 HOLD cycles; back to PLAY.
- Hit:
  - Stimulus: DSW=1, BTN falls while MATCH=1.
  - Response: exactly one SCORE_INC pulse 3 edges after the BTN edge; RESULT_HIT=1; MISSES unchanged; STEP_EN period 2.
- Early end on misses: two wrong presses (MATCH=0) -> MISSES=2, GAME_OVER=1 after the second HOLD; ROUND=2.
- Full game: three hits -> ROUND=3, GAME_OVER=1, three SCORE_INC pulses total; a new START gives SCORE_CLR and ROUND=0.
- Simultaneous events: press on the cycle of the 5th tick with MATCH=1 -> counted as a hit, no STEP_EN that cycle, no miss; DSW toggled mid-PLAY -> step period unchanged.
- Reset mid-PLAY: assert RST -> next sample shows IDLE, all outputs 0, no SCORE_INC; BTN presses in IDLE and HOLD produce no pulses.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and default timing constants for the Precision Button Press game.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    PLAY = 3'd2,
    HOLD = 3'd3,
    OVER = 3'd4
  } state_t;

  localparam int unsigned EASY_DIV_DEF      = 50_000_000;
  localparam int unsigned HARD_DIV_DEF      = 12_500_000;
  localparam int unsigned HOLD_CYC_DEF      = 100_000_000;
  localparam int unsigned TIMEOUT_STEPS_DEF = 32;
  localparam int unsigned ROUNDS_DEF        = 8;
  localparam int unsigned MAX_MISS_DEF      = 3;
  localparam int unsigned DIV_W             = 32;
  localparam int unsigned ROUND_W           = 4;
  localparam int unsigned MISS_W            = 2;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Sweep step enable: while run is high, pulses tick once every divisor cycles.
module step_tick_gen
  import game_pkg::*;
#(
  parameter int unsigned CNT_W = 26
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clear,
  input  logic             run,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic             wrap_c;

  assign wrap_c = run && (DIV_W'(cnt) == (divisor - DIV_W'(1)));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= wrap_c;
      if (wrap_c) begin
        cnt <= '0;
      end else if (run) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/game_round_ctrl.sv
// Round/game sequencer: arms rounds, paces the LED sweep, judges presses,
// drives score pulses and tracks rounds and misses until the game ends.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned EASY_DIV      = EASY_DIV_DEF,
  parameter int unsigned HARD_DIV      = HARD_DIV_DEF,
  parameter int unsigned HOLD_CYC      = HOLD_CYC_DEF,
  parameter int unsigned TIMEOUT_STEPS = TIMEOUT_STEPS_DEF,
  parameter int unsigned ROUNDS        = ROUNDS_DEF,
  parameter int unsigned MAX_MISS      = MAX_MISS_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               BTN,
  input  logic               DSW,
  input  logic               MATCH,
  output logic               STEP_EN,
  output logic               SWEEP_RUN,
  output logic               SCORE_INC,
  output logic               SCORE_CLR,
  output logic               RESULT_HIT,
  output logic               RESULT_MISS,
  output logic [ROUND_W-1:0] ROUND,
  output logic [MISS_W-1:0]  MISSES,
  output logic               GAME_OVER,
  output logic [2:0]         STATE
);

  localparam int unsigned MAX_DIV = (EASY_DIV > HARD_DIV) ? EASY_DIV : HARD_DIV;
  localparam int unsigned TICK_W  = cnt_width(MAX_DIV);
  localparam int unsigned HOLD_W  = cnt_width(HOLD_CYC);
  localparam int unsigned STEP_W  = $clog2(TIMEOUT_STEPS + 1);

  state_t state, state_n;

  logic btn_s1, btn_s2, btn_d;
  logic start_s1, start_s2, start_d;
  logic press_c, start_c, step_tick;

  logic [DIV_W-1:0]   div_q, div_n;
  logic [STEP_W-1:0]  step_cnt, step_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_n;
  logic [ROUND_W-1:0] round_q, round_n;
  logic [MISS_W-1:0]  miss_q, miss_n, miss_sat_c;
  logic hit_q, hit_n, missr_q, missr_n;
  logic step_en_q, step_en_n, inc_q, inc_n, clr_q, clr_n;
  logic sweep_q, over_q;

  // Two-flop synchronizers plus one history flop for edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      btn_d    <= 1'b0;
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      start_d  <= 1'b0;
    end else begin
      btn_s1   <= BTN;
      btn_s2   <= btn_s1;
      btn_d    <= btn_s2;
      start_s1 <= START;
      start_s2 <= start_s1;
      start_d  <= start_s2;
    end
  end

  assign press_c    = btn_d & ~btn_s2;
  assign start_c    = start_s2 & ~start_d;
  assign miss_sat_c = (miss_q == 2'd3) ? miss_q : miss_q + 2'd1;

  step_tick_gen #(
    .CNT_W (TICK_W)
  ) u_tick (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (state == ARM),
    .run     (state == PLAY),
    .divisor (div_q),
    .tick    (step_tick)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    div_n     = div_q;
    step_n    = step_cnt;
    hold_n    = '0;
    round_n   = round_q;
    miss_n    = miss_q;
    hit_n     = hit_q;
    missr_n   = missr_q;
    step_en_n = 1'b0;
    inc_n     = 1'b0;
    clr_n     = 1'b0;
    case (state)
      IDLE, OVER: begin
        if (start_c) begin
          clr_n   = 1'b1;
          round_n = '0;
          miss_n  = '0;
          hit_n   = 1'b0;
          missr_n = 1'b0;
          state_n = ARM;
        end
      end
      ARM: begin
        div_n   = DSW ? DIV_W'(HARD_DIV) : DIV_W'(EASY_DIV);
        step_n  = '0;
        state_n = PLAY;
      end
      PLAY: begin
        // Press outranks both timeout and the step that would land this cycle.
        if (press_c) begin
          if (MATCH) begin
            inc_n = 1'b1;
            hit_n = 1'b1;
          end else begin
            miss_n  = miss_sat_c;
            missr_n = 1'b1;
          end
          state_n = HOLD;
        end else if (step_cnt == STEP_W'(TIMEOUT_STEPS)) begin
          miss_n  = miss_sat_c;
          missr_n = 1'b1;
          state_n = HOLD;
        end else if (step_tick) begin
          step_en_n = 1'b1;
          step_n    = step_cnt + STEP_W'(1);
        end
      end
      HOLD: begin
        if (hold_cnt == HOLD_W'(HOLD_CYC - 1)) begin
          round_n = round_q + 4'd1;
          hit_n   = 1'b0;
          missr_n = 1'b0;
          if ((round_q + 4'd1 == ROUND_W'(ROUNDS)) || (miss_q == MISS_W'(MAX_MISS))) begin
            state_n = OVER;
          end else begin
            state_n = ARM;
          end
        end else begin
          hold_n = hold_cnt + HOLD_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Counters and registered outputs, all derived from the next-state decode.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_q     <= '0;
      step_cnt  <= '0;
      hold_cnt  <= '0;
      round_q   <= '0;
      miss_q    <= '0;
      hit_q     <= 1'b0;
      missr_q   <= 1'b0;
      step_en_q <= 1'b0;
      inc_q     <= 1'b0;
      clr_q     <= 1'b0;
      sweep_q   <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      div_q     <= div_n;
      step_cnt  <= step_n;
      hold_cnt  <= hold_n;
      round_q   <= round_n;
      miss_q    <= miss_n;
      hit_q     <= hit_n;
      missr_q   <= missr_n;
      step_en_q <= step_en_n;
      inc_q     <= inc_n;
      clr_q     <= clr_n;
      sweep_q   <= (state_n == PLAY);
      over_q    <= (state_n == OVER);
    end
  end

  assign STEP_EN     = step_en_q;
  assign SWEEP_RUN   = sweep_q;
  assign SCORE_INC   = inc_q;
  assign SCORE_CLR   = clr_q;
  assign RESULT_HIT  = hit_q;
  assign RESULT_MISS = missr_q;
  assign ROUND       = round_q;
  assign MISSES      = miss_q;
  assign GAME_OVER   = over_q;
  assign STATE       = state;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl with small divisors; edge numbers Ek count
// from the cycle START is raised (E3 = ARM, E4 = first PLAY cycle).
module tb_game_round_ctrl;

  logic CLK = 1'b0;
  logic RST, START, BTN, DSW, MATCH;
  logic STEP_EN, SWEEP_RUN, SCORE_INC, SCORE_CLR, RESULT_HIT, RESULT_MISS, GAME_OVER;
  logic [3:0] ROUND;
  logic [1:0] MISSES;
  logic [2:0] STATE;

  int n_assert = 0;
  int n_fail   = 0;
  int inc_cnt  = 0;
  int clr_cnt  = 0;
  int overlap  = 0;
  int bad, pulses, base_inc, base_clr;

  game_round_ctrl #(
    .EASY_DIV      (4),
    .HARD_DIV      (2),
    .HOLD_CYC      (3),
    .TIMEOUT_STEPS (5),
    .ROUNDS        (3),
    .MAX_MISS      (2)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .START       (START),
    .BTN         (BTN),
    .DSW         (DSW),
    .MATCH       (MATCH),
    .STEP_EN     (STEP_EN),
    .SWEEP_RUN   (SWEEP_RUN),
    .SCORE_INC   (SCORE_INC),
    .SCORE_CLR   (SCORE_CLR),
    .RESULT_HIT  (RESULT_HIT),
    .RESULT_MISS (RESULT_MISS),
    .ROUND       (ROUND),
    .MISSES      (MISSES),
    .GAME_OVER   (GAME_OVER),
    .STATE       (STATE)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (SCORE_INC === 1'b1) inc_cnt++;
    if (SCORE_CLR === 1'b1) clr_cnt++;
    if (SCORE_INC === 1'b1 && SCORE_CLR === 1'b1) overlap++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] outs();
    return {STEP_EN, SWEEP_RUN, SCORE_INC, SCORE_CLR, RESULT_HIT, RESULT_MISS,
            ROUND, MISSES, GAME_OVER, STATE};
  endfunction

  task automatic do_reset();
    RST = 1'b1; START = 1'b0; BTN = 1'b1; MATCH = 1'b0; DSW = 1'b0;
    tick(); tick();
    RST = 1'b0;
    tick(); tick(); tick();
  endtask

  // Pulses START; returns just after E4 (first PLAY cycle).
  task automatic start_game(input logic dsw);
    DSW = dsw;
    START = 1'b1;
    tick(); tick();
    START = 1'b0;
    check("start_no_early_clr", SCORE_CLR, 0);
    tick();
    check("start_clr", SCORE_CLR, 1);
    check("start_arm", STATE, 1);
    check("start_round0", ROUND, 0);
    check("start_miss0", MISSES, 0);
    check("start_not_over", GAME_OVER, 0);
    tick();
    check("start_play", STATE, 2);
    check("start_clr_1cyc", SCORE_CLR, 0);
    check("start_sweep", SWEEP_RUN, 1);
  endtask

  // Walks edges E5..Elast comparing STEP_EN to a first/period pattern.
  task automatic step_window(input int last, input int first, input int period,
                             input int start_at, input int dsw_at, input int btn_at,
                             output int nbad, output int npulse);
    nbad = 0;
    npulse = 0;
    for (int k = 5; k <= last; k++) begin
      if (k == start_at) START = 1'b1;
      if (k == start_at + 2) START = 1'b0;
      if (k == dsw_at) DSW = ~DSW;
      if (k == btn_at) BTN = 1'b0;
      tick();
      if (STEP_EN !== ((k >= first) && ((k - first) % period == 0))) nbad++;
      if (STEP_EN === 1'b1) npulse++;
    end
  endtask

  // BTN low for three edges: the judged result is visible on return.
  task automatic press_btn();
    BTN = 1'b0;
    tick(); tick(); tick();
    BTN = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] exp, input int budget, input string tag);
    int n = 0;
    while (STATE !== exp && n < budget) begin
      tick();
      n++;
    end
    check(tag, STATE, exp);
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; BTN = 1'b1; DSW = 1'b0; MATCH = 1'b0;
    tick(); tick();
    check("reset_outs", 32'(outs()), 0);
    RST = 1'b0;
    tick(); tick(); tick();
    check("idle_state", STATE, 0);

    // Press in IDLE is ignored
    BTN = 1'b0;
    tick(); tick(); tick(); tick();
    BTN = 1'b1;
    tick(); tick(); tick();
    check("idle_press_no_inc", inc_cnt, 0);
    check("idle_press_state", STATE, 0);

    // Start then timeout, easy divisor; START re-pulsed mid-PLAY
    start_game(1'b0);
    base_clr = clr_cnt;
    step_window(25, 9, 4, 10, -1, -1, bad, pulses);
    check("t1_step_pattern", bad, 0);
    check("t1_step_pulses", pulses, 5);
    check("t1_start_ignored", clr_cnt - base_clr, 0);
    check("t1_still_play", STATE, 2);
    check("t1_no_miss_yet", RESULT_MISS, 0);
    tick();
    check("t1_hold", STATE, 3);
    check("t1_result_miss", RESULT_MISS, 1);
    check("t1_misses", MISSES, 1);
    check("t1_sweep_off", SWEEP_RUN, 0);
    BTN = 1'b0;
    tick(); tick();
    BTN = 1'b1;
    check("t1_hold_e28", STATE, 3);
    tick();
    check("t1_round", ROUND, 1);
    check("t1_result_clear", RESULT_MISS, 0);
    check("t1_arm", STATE, 1);
    check("t1_hold_press_ignored", MISSES, 1);
    check("t1_no_inc", inc_cnt, 0);
    tick();
    check("t1_back_to_play", STATE, 2);

    // Hit on hard divisor
    do_reset();
    start_game(1'b1);
    MATCH = 1'b1;
    base_inc = inc_cnt;
    step_window(11, 7, 2, -1, -1, 10, bad, pulses);
    check("t2_step_pattern", bad, 0);
    check("t2_step_pulses", pulses, 3);
    check("t2_no_inc_e11", SCORE_INC, 0);
    tick();
    check("t2_inc", SCORE_INC, 1);
    check("t2_hit", RESULT_HIT, 1);
    check("t2_no_step", STEP_EN, 0);
    check("t2_misses", MISSES, 0);
    check("t2_hold", STATE, 3);
    BTN = 1'b1;
    tick();
    check("t2_inc_1cyc", SCORE_INC, 0);
    wait_state(3'd2, 10, "t2_next_round");
    check("t2_inc_count", inc_cnt - base_inc, 1);
    check("t2_round", ROUND, 1);

    // Early end on two misses
    do_reset();
    start_game(1'b0);
    MATCH = 1'b0;
    base_inc = inc_cnt;
    press_btn();
    check("t3_hold1", STATE, 3);
    check("t3_miss1", MISSES, 1);
    check("t3_rmiss1", RESULT_MISS, 1);
    wait_state(3'd2, 20, "t3_round2");
    check("t3_round1", ROUND, 1);
    press_btn();
    check("t3_miss2", MISSES, 2);
    wait_state(3'd4, 20, "t3_over");
    check("t3_game_over", GAME_OVER, 1);
    check("t3_round2", ROUND, 2);
    check("t3_miss_hold", MISSES, 2);
    check("t3_rmiss_clear", RESULT_MISS, 0);
    check("t3_no_inc", inc_cnt - base_inc, 0);

    // Full game of three hits, then restart from OVER
    do_reset();
    start_game(1'b1);
    MATCH = 1'b1;
    base_inc = inc_cnt;
    for (int r = 0; r < 3; r++) begin
      press_btn();
      check("t4_hit", RESULT_HIT, 1);
      if (r < 2) wait_state(3'd2, 20, "t4_next_play");
    end
    wait_state(3'd4, 20, "t4_over");
    check("t4_round3", ROUND, 3);
    check("t4_game_over", GAME_OVER, 1);
    check("t4_inc_total", inc_cnt - base_inc, 3);
    base_clr = clr_cnt;
    start_game(1'b0);
    check("t4_restart_clr", clr_cnt - base_clr, 1);

    // Press on the 5th tick with DSW flipped mid-PLAY
    do_reset();
    start_game(1'b0);
    MATCH = 1'b1;
    step_window(24, 9, 4, -1, 7, 23, bad, pulses);
    check("t5_step_pattern", bad, 0);
    check("t5_step_pulses", pulses, 4);
    tick();
    check("t5_no_step", STEP_EN, 0);
    check("t5_inc", SCORE_INC, 1);
    check("t5_hit", RESULT_HIT, 1);
    check("t5_no_miss", RESULT_MISS, 0);
    check("t5_misses", MISSES, 0);
    check("t5_hold", STATE, 3);
    BTN = 1'b1;

    // Reset mid-PLAY just before a judged hit
    do_reset();
    start_game(1'b0);
    MATCH = 1'b1;
    base_inc = inc_cnt;
    BTN = 1'b0;
    tick();
    RST = 1'b1;
    #1;
    check("t6_async_outs", 32'(outs()), 0);
    tick();
    check("t6_outs", 32'(outs()), 0);
    BTN = 1'b1;
    tick();
    RST = 1'b0;
    tick(); tick(); tick();
    check("t6_idle", STATE, 0);
    check("t6_no_inc", inc_cnt - base_inc, 0);

    check("inc_clr_overlap", overlap, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
